tetris_input_ctrl: RTL and testbench

Parametrised player-input front end for the Tetris LED game: N push-button channels, each synchronised, debounced and converted into one-cycle move pulses, with optional per-channel auto-repeat while a button is held. Sits between the board buttons and tetris_logic, replacing raw moveR/moveL levels with clean, rate-limited move commands (right, left, rotate, drop, ...).

---
 rtl/tetris_pkg.sv | 11 +
 rtl/tetris_btn_chan.sv | 79 +++++++
 rtl/tetris_input_ctrl.sv | 33 +++
 tb/tb_tetris_input_ctrl.sv | 91 +++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared types and constants for the Tetris button front end.
package tetris_pkg;
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_ROT   = 2;
    localparam int BTN_DROP  = 3;
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/tetris_btn_chan.sv
// tetris_btn_chan: one button channel - synchroniser, debouncer and auto-repeat FSM.
module tetris_btn_chan
    import tetris_pkg::*;
#(
    parameter int DEB_CYCLES    = 4,
    parameter int REPEAT_DELAY  = 10,
    parameter int REPEAT_PERIOD = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic repeat_en,
    input  logic raw,
    output logic held,
    output logic pulse
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(imax(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer, timer_nx;
    rpt_state_e    state, state_nx;
    logic          flip, rise, fall, pulse_nx;

    // flip marks the edge where the debounced level changes; the FSM reacts on the same edge
    assign flip = (sync[1] != held) && (cnt == CW'(DEB_CYCLES - 1));
    assign rise = flip && sync[1];
    assign fall = flip && !sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            held  <= 1'b0;
            state <= IDLE;
            timer <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            cnt   <= (sync[1] == held || flip) ? '0 : cnt + 1'b1;
            held  <= flip ? sync[1] : held;
            state <= state_nx;
            timer <= timer_nx;
            pulse <= pulse_nx;
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        pulse_nx = 1'b0;
        if (fall) begin
            state_nx = IDLE;
            timer_nx = '0;
        end else if (!en) begin
            // paused: held buttons park in DELAY so the full delay restarts on resume
            state_nx = (held || rise) ? DELAY : IDLE;
            timer_nx = '0;
        end else if (rise) begin
            state_nx = DELAY;
            timer_nx = '0;
            pulse_nx = 1'b1;
        end else begin
            case (state)
                DELAY: if (repeat_en) begin
                    pulse_nx = (timer == TW'(REPEAT_DELAY - 1));
                    timer_nx = pulse_nx ? '0 : timer + 1'b1;
                    state_nx = pulse_nx ? REPEAT : DELAY;
                end
                REPEAT: begin
                    pulse_nx = (timer == TW'(REPEAT_PERIOD - 1));
                    timer_nx = pulse_nx ? '0 : timer + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl: N debounced button channels producing rate-limited move pulses.
module tetris_input_ctrl
    import tetris_pkg::*;
#(
    parameter int               N_BTN         = 2,
    parameter int               DEB_CYCLES    = 4,
    parameter int               REPEAT_DELAY  = 10,
    parameter int               REPEAT_PERIOD = 3,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_held,
    output logic [N_BTN-1:0] btn_pulse
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        tetris_btn_chan #(
            .DEB_CYCLES   (DEB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .repeat_en(REPEAT_MASK[i]),
            .raw      (btn_raw[i]),
            .held     (btn_held[i]),
            .pulse    (btn_pulse[i])
        );
    end
endmodule

// File: tb/tb_tetris_input_ctrl.sv
// tb_tetris_input_ctrl: directed checks of debounce, press/repeat timing, pause and reset.
module tb_tetris_input_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [2:0] btn_raw = '0;
    logic [2:0] btn_held, btn_pulse;
    int         checks = 0;
    int         errors = 0;

    tetris_input_ctrl #(
        .N_BTN(3), .DEB_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_MASK(3'b011)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .btn_raw(btn_raw), .btn_held(btn_held), .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s edge %0d got %b expected %b", tag, k, got, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("reset_pulse", 0, btn_pulse, 3'b000);
        chk("reset_held", 0, btn_held, 3'b000);
        rst = 1'b0;
        tick();
        // channel 0 held 24 edges then released; repeats continue while still debounced-high
        btn_raw = 3'b001;
        for (int k = 1; k <= 35; k++) begin
            tick();
            chk("t1_pulse", k, btn_pulse, (k inside {6, 16, 19, 22, 25, 28}) ? 3'b001 : 3'b000);
            chk("t1_held", k, btn_held, (k >= 6 && k <= 29) ? 3'b001 : 3'b000);
            if (k == 24) btn_raw = 3'b000;
        end
        // 3-sample glitch on channel 1
        btn_raw = 3'b010;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("t2_pulse", k, btn_pulse, 3'b000);
            chk("t2_held", k, btn_held, 3'b000);
            if (k == 3) btn_raw = 3'b000;
        end
        // channel 2 has repeat disabled
        btn_raw = 3'b100;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("t3_pulse", k, btn_pulse, (k == 6) ? 3'b100 : 3'b000);
            chk("t3_held", k, btn_held, (k >= 6) ? 3'b100 : 3'b000);
        end
        btn_raw = 3'b000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t3_rel_pulse", k, btn_pulse, 3'b000);
            chk("t3_rel_held", k, btn_held, (k < 6) ? 3'b100 : 3'b000);
        end
        // channels 0 and 1 together, with a 5-cycle pause in REPEAT
        btn_raw = 3'b011;
        for (int k = 1; k <= 42; k++) begin
            tick();
            chk("t4_pulse", k, btn_pulse, (k inside {6, 16, 19, 22, 38, 41}) ? 3'b011 : 3'b000);
            chk("t4_held", k, btn_held, (k >= 6) ? 3'b011 : 3'b000);
            if (k == 23) en = 1'b0;
            if (k == 28) en = 1'b1;
        end
        // reset mid-REPEAT with the buttons still down
        rst = 1'b1;
        tick();
        chk("t5_rst_pulse", 0, btn_pulse, 3'b000);
        chk("t5_rst_held", 0, btn_held, 3'b000);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t5_pulse", k, btn_pulse, (k == 6) ? 3'b011 : 3'b000);
            chk("t5_held", k, btn_held, (k >= 6) ? 3'b011 : 3'b000);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
